// File: rtl/i2s_frame_writer.sv
// rtl/i2s_frame_writer.sv - I2S single-channel capture with ping-pong frame buffer write control
module i2s_frame_writer #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 10,
    parameter bit CHANNEL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ws_i,
    input  logic                 sd_i,
    output logic [DATA_BITS-1:0] buff_wdata_o,
    output logic [ADDR_BITS-1:0] buff_waddr_o,
    output logic                 buff_we_o,
    output logic                 buff_sel_o,
    output logic                 frame_done_o,
    output logic                 sync_err_o
);

    // bit counter must hold DATA_BITS itself, which doubles as the idle value
    localparam int                    CNT_BITS  = $clog2(DATA_BITS + 1);
    localparam logic [CNT_BITS-1:0]   CNT_FULL  = CNT_BITS'(DATA_BITS);
    localparam logic [CNT_BITS-1:0]   CNT_LAST  = CNT_BITS'(DATA_BITS - 1);
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR = '1;

    // word-select edge detection; primed_q masks the first cycle after reset
    logic                 primed_q;
    logic                 ws_d_q;
    logic                 ws_edge;

    // slot capture state
    logic [CNT_BITS-1:0]  bit_cnt_q,  bit_cnt_d;
    logic                 slot_ch_q,  slot_ch_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic                 word_rdy_q, word_rdy_d;
    logic                 capturing;
    logic                 present;
    logic                 short_slot;

    // buffer write side
    logic [ADDR_BITS-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DATA_BITS-1:0] wdata_q,    wdata_d;
    logic [ADDR_BITS-1:0] waddr_q,    waddr_d;
    logic                 we_q,       we_d;
    logic                 swap_pend_q, swap_pend_d;
    logic                 sel_q,      sel_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;

    // decode the events that drive capture and write decisions this cycle
    always_comb begin
        ws_edge    = primed_q && (ws_i != ws_d_q);
        capturing  = (bit_cnt_q < CNT_FULL);
        // the word is complete one cycle after its LSB was shifted in
        present    = word_rdy_q && (slot_ch_q == CHANNEL);
        // a slot of our channel cut off after some but not all bits arrived
        short_slot = ws_edge && (slot_ch_q == CHANNEL) && capturing
                     && (bit_cnt_q != '0);
    end

    // next-state for the serial shifter and slot tracking
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        slot_ch_d  = slot_ch_q;
        shreg_d    = shreg_q;
        word_rdy_d = 1'b0;
        if (ws_edge) begin
            // a new slot starts; whatever was partially shifted is abandoned
            bit_cnt_d = '0;
            slot_ch_d = ws_i;
        end else if (capturing) begin
            shreg_d    = {shreg_q[DATA_BITS-2:0], sd_i};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            word_rdy_d = (bit_cnt_q == CNT_LAST);
        end
    end

    // next-state for the write port, bank select and error flag
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        we_d        = present;
        swap_pend_d = present && (wr_ptr_q == LAST_ADDR);
        if (present) begin
            wdata_d  = shreg_q;
            waddr_d  = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        // swap one cycle after the last address so it is written in the old bank
        sel_d  = sel_q ^ swap_pend_q;
        done_d = swap_pend_q;
        err_d  = err_q | short_slot;
    end

    // edge-detect registers; ws_d_q tracks ws_i even during reset
    always_ff @(posedge clk) begin
        ws_d_q <= ws_i;
        if (rst) begin
            primed_q <= 1'b0;
        end else begin
            primed_q <= 1'b1;
        end
    end

    // capture state registers; idle counter value blocks capture until a ws edge
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= CNT_FULL;
            slot_ch_q  <= 1'b0;
            shreg_q    <= '0;
            word_rdy_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            slot_ch_q  <= slot_ch_d;
            shreg_q    <= shreg_d;
            word_rdy_q <= word_rdy_d;
        end
    end

    // write-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            swap_pend_q <= 1'b0;
            sel_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            swap_pend_q <= swap_pend_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign buff_wdata_o = wdata_q;
    assign buff_waddr_o = waddr_q;
    assign buff_we_o    = we_q;
    assign buff_sel_o   = sel_q;
    assign frame_done_o = done_q;
    assign sync_err_o   = err_q;

endmodule

// File: tb/tb_i2s_frame_writer.sv
// tb/tb_i2s_frame_writer.sv - bench for i2s_frame_writer with a slot-level write model
module tb_i2s_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ws_i = 1'b0;
    logic        sd_i = 1'b0;
    logic [15:0] buff_wdata_o;
    logic [9:0]  buff_waddr_o;
    logic        buff_we_o;
    logic        buff_sel_o;
    logic        frame_done_o;
    logic        sync_err_o;

    always #5 clk = ~clk;

    i2s_frame_writer #(.DATA_BITS(16), .ADDR_BITS(10), .CHANNEL(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .ws_i        (ws_i),
        .sd_i        (sd_i),
        .buff_wdata_o(buff_wdata_o),
        .buff_waddr_o(buff_waddr_o),
        .buff_we_o   (buff_we_o),
        .buff_sel_o  (buff_sel_o),
        .frame_done_o(frame_done_o),
        .sync_err_o  (sync_err_o)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [9:0]  addr;
        logic        sel;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    int   cyc = 0;
    wr_t  exp_q[$];
    lit_t lit_q[$];
    int   done_q[$];
    int   wr_count = 0;
    int   err_at = -1;
    bit   chk_on = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] m_wdata = '0;
    logic [9:0]  m_waddr = '0;
    logic        m_sel = 1'b0;
    logic        m_err = 1'b0;
    logic        e_we;
    logic        e_done;
    wr_t         w;
    lit_t        l;

    always @(posedge clk) cyc <= cyc + 1;

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // per-cycle comparison against the slot-level model
    always @(negedge clk) begin
        if (chk_on) begin
            e_we   = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            e_done = (done_q.size() > 0) && (done_q[0] == cyc);
            if (e_we) begin
                w       = exp_q.pop_front();
                m_wdata = w.data;
                m_waddr = w.addr;
                if (w.addr == 10'h3FF) done_q.push_back(cyc + 1);
            end
            if (e_done) begin
                void'(done_q.pop_front());
                m_sel = ~m_sel;
            end
            if (err_at == cyc) m_err = 1'b1;
            chk("we",    32'(buff_we_o),    32'(e_we));
            chk("wdata", 32'(buff_wdata_o), 32'(m_wdata));
            chk("waddr", 32'(buff_waddr_o), 32'(m_waddr));
            chk("sel",   32'(buff_sel_o),   32'(m_sel));
            chk("done",  32'(frame_done_o), 32'(e_done));
            chk("err",   32'(sync_err_o),   32'(m_err));
            if (e_we) chk("write_bank", 32'(buff_sel_o), 32'(w.sel));
            if (buff_we_o) we_cnt++;
            if (frame_done_o) done_cnt++;
            while (lit_q.size() > 0) begin
                l = lit_q.pop_front();
                chk(l.name, l.act, l.exp);
            end
            if (rst) begin
                exp_q.delete();
                done_q.delete();
                m_wdata = '0;
                m_waddr = '0;
                m_sel   = 1'b0;
                m_err   = 1'b0;
            end
        end
    end

    task lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_q.push_back('{name: name, act: act, exp: exp});
    endtask

    // one I2S slot starting at a negedge: ws edge, then MSB-first data, then junk
    task send_slot(input logic ws, input logic [15:0] data, input int len);
        int c0;
        c0 = cyc;
        if (ws == 1'b0 && len >= 17) begin
            exp_q.push_back('{cyc: c0 + 18, data: data, addr: wr_count[9:0], sel: wr_count[10]});
            wr_count++;
        end
        for (int i = 0; i < len; i++) begin
            ws_i = ws;
            if (i >= 1 && i <= 16) sd_i = data[16-i];
            else sd_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            ws_i = 1'($urandom_range(0, 1));
            sd_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst = 1'b0;
        ws_i = 1'b1;
        sd_i = 1'b0;
        wr_count = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] ext [3];
        ext[0] = 16'h8000;
        ext[1] = 16'h7FFF;
        ext[2] = 16'h0000;

        @(negedge clk);
        chk_on = 1'b1;
        do_reset(2);
        lit("rst_sel", 32'(buff_sel_o), 32'h0);
        lit("rst_err", 32'(sync_err_o), 32'h0);
        lit("rst_we",  32'(buff_we_o),  32'h0);

        // single left sample followed by a right slot of all ones
        send_slot(1'b0, 16'hA5C3, 32);
        send_slot(1'b1, 16'hFFFF, 32);
        lit("a5c3_data", 32'(buff_wdata_o), 32'h0000A5C3);
        lit("a5c3_addr", 32'(buff_waddr_o), 32'h0);
        lit("a5c3_cnt",  32'(we_cnt),       32'h1);

        // extreme values at consecutive addresses
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            send_slot(1'b0, ext[i], 32);
            send_slot(1'b1, 16'hFFFF, 32);
            lit("ext_data", 32'(buff_wdata_o), 32'(ext[i]));
            lit("ext_addr", 32'(buff_waddr_o), 32'(i));
        end

        // left slot cut after 8 bits; error appears on the following ws edge
        err_at = cyc + 10;
        send_slot(1'b0, 16'h00FF, 9);
        send_slot(1'b1, 16'hFFFF, 32);
        lit("short_err", 32'(sync_err_o), 32'h1);
        lit("short_nowr", 32'(buff_waddr_o), 32'h2);
        send_slot(1'b0, 16'h1234, 32);
        send_slot(1'b1, 16'hFFFF, 32);
        lit("after_short_data", 32'(buff_wdata_o), 32'h1234);
        lit("after_short_addr", 32'(buff_waddr_o), 32'h3);
        lit("err_sticky",       32'(sync_err_o),   32'h1);

        // fill up to 500 samples, leave a partial word, then reset mid-frame
        for (int i = 4; i < 500; i++) begin
            send_slot(1'b0, 16'(i * 37 + 16'h5A5A), 18);
            send_slot(1'b1, 16'hFFFF, 2);
        end
        lit("pre_rst_addr", 32'(buff_waddr_o), 32'd499);
        send_slot(1'b0, 16'hDEAD, 6);
        do_reset(2);
        lit("midrst_sel", 32'(buff_sel_o), 32'h0);
        lit("midrst_err", 32'(sync_err_o), 32'h0);
        send_slot(1'b0, 16'hBEEF, 18);
        send_slot(1'b1, 16'hFFFF, 2);
        lit("midrst_data", 32'(buff_wdata_o), 32'h0000BEEF);
        lit("midrst_addr", 32'(buff_waddr_o), 32'h0);

        // two full frames with value = index
        do_reset(2);
        for (int i = 0; i < 2048; i++) begin
            send_slot(1'b0, 16'(i), 18);
            send_slot(1'b1, 16'hFFFF, 2);
            if (i == 1022) lit("pre_swap_sel", 32'(buff_sel_o), 32'h0);
            if (i == 1023) begin
                lit("frame1_sel",  32'(buff_sel_o), 32'h1);
                lit("frame1_done", 32'(done_cnt),   32'h1);
                lit("frame1_last", 32'(buff_waddr_o), 32'h3FF);
            end
            if (i == 1024) begin
                lit("wrap_addr", 32'(buff_waddr_o), 32'h0);
                lit("wrap_data", 32'(buff_wdata_o), 32'h0400);
            end
        end
        lit("frame2_sel",  32'(buff_sel_o), 32'h0);
        lit("frame2_done", 32'(done_cnt),   32'h2);
        lit("frame2_data", 32'(buff_wdata_o), 32'h07FF);

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
